// File: rtl/arm_cpu_pkg.sv
// Shared types and encodings for the multicycle ArmCpu control path.
// Optional MEM_WAIT_EN adds memory wait states to the controller.
package arm_cpu_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_SBC = 4'b0110;
  localparam logic [3:0] ALU_RSC = 4'b0111;
  localparam logic [3:0] ALU_TST = 4'b1000;
  localparam logic [3:0] ALU_TEQ = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_CMN = 4'b1011;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_RN     = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_ALUOUT = 2'd2;

  localparam logic [1:0] SRCB_RM   = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] IMM_DP  = 2'd0;
  localparam logic [1:0] IMM_MEM = 2'd1;
  localparam logic [1:0] IMM_BR  = 2'd2;

  function automatic logic [1:0] imm_for_op(input logic [1:0] op);
    unique case (op)
      OP_MEM:  return IMM_MEM;
      OP_BR:   return IMM_BR;
      default: return IMM_DP;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition-code evaluation.
// Flags load only when the FSM requests it and the condition passes.
module cond_unit
  import arm_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_en,
  output logic [3:0] flags_q,
  output logic       cond_ok
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_ff @(posedge clk) begin
    if (reset)
      flags_q <= 4'b0000;
    else if (flag_en && cond_ok)
      flags_q <= alu_flags;
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      COND_NV: cond_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ArmCpu control FSM and per-state output decode.
// Define MEM_WAIT_EN to add the mem_ready wait-state input.
module multicycle_controller
  import arm_cpu_pkg::*;
#(
  parameter int ALU_CTL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cond,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  input  logic [3:0]           alu_flags,
`ifdef MEM_WAIT_EN
  input  logic                 mem_ready,
`endif
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [3:0]           flags_q
);

  state_t state, next;
  logic   cond_ok;
  logic   flag_en;
  logic   mem_rdy;
  logic   go;
  logic   no_wb;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign go      = !reset;
  assign no_wb   = (funct[4:3] == 2'b10);
  assign flag_en = go && funct[0] &&
                   (state == EXECR || state == EXECI);

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_en   (flag_en),
    .flags_q   (flags_q),
    .cond_ok   (cond_ok)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= FETCH;
    else
      state <= next;
  end

  always_comb begin
    next = FETCH;
    unique case (state)
      FETCH:    next = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        unique case (op)
          OP_MEM:  next = MEMADR;
          OP_DP:   next = funct[5] ? EXECI : EXECR;
          OP_BR:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR:   next = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next = mem_rdy ? MEMWB : MEMREAD;
      MEMWB:    next = FETCH;
      MEMWRITE: next = mem_rdy ? FETCH : MEMWRITE;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      BRANCH:   next = FETCH;
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_RN;
    alu_src_b  = SRCB_RM;
    result_src = RES_ALUOUT;
    imm_src    = IMM_DP;
    alu_ctl    = ALU_CTL_W'(ALU_ADD);
    unique case (state)
      FETCH: begin
        ir_write   = go && mem_rdy;
        pc_write   = go && mem_rdy;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        imm_src   = imm_for_op(op);
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_MEM;
      end
      MEMREAD: adr_src = ADR_ALUOUT;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = go && cond_ok && (rd != 4'd15);
        pc_write   = go && cond_ok && (rd == 4'd15);
      end
      MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = go && cond_ok && mem_rdy;
      end
      EXECR: alu_ctl = ALU_CTL_W'(funct[4:1]);
      EXECI: begin
        alu_src_b = SRCB_IMM;
        alu_ctl   = ALU_CTL_W'(funct[4:1]);
      end
      ALUWB: begin
        reg_write = go && cond_ok && !no_wb && (rd != 4'd15);
        pc_write  = go && cond_ok && !no_wb && (rd == 4'd15);
      end
      BRANCH: begin
        alu_src_a  = SRCA_ALUOUT;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_BR;
        result_src = RES_ALU;
        pc_write   = go && cond_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs.
// Define MEM_WAIT_EN to also exercise fetch wait states.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [3:0] alu_ctl;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cond = 4'hE;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'd0;
  logic [3:0] rd = 4'd0;
  logic [3:0] alu_flags = 4'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [3:0] alu_ctl;
  logic [3:0] flags_q;

  int n_chk = 0;
  int n_fail = 0;

  ctl_t  exp_q[$];
  string tag_q[$];

  multicycle_controller #(.ALU_CTL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .alu_flags  (alu_flags),
`ifdef MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_ctl    (alu_ctl),
    .flags_q    (flags_q)
  );

  always #5 clk = !clk;

  function automatic ctl_t observed();
    return {pc_write, adr_src, mem_write, ir_write, reg_write,
            alu_src_a, alu_src_b, result_src, imm_src, alu_ctl};
  endfunction

  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.alu_ctl = 4'b0100;
    return c;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t o, input ctl_t e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] o,
                      input logic [3:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input ctl_t c);
    exp_q.push_back(c);
    tag_q.push_back(tag);
  endtask

  // Expected per-cycle outputs of one instruction; ok is the condition result.
  task automatic push_instr(input string nm, input logic [1:0] o,
                            input logic [5:0] f, input logic [3:0] r,
                            input logic ok);
    ctl_t c;
    c = base();
    c.ir_write = 1'b1; c.pc_write = 1'b1;
    c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.result_src = 2'd2;
    push({nm, "/fetch"}, c);
    c = base();
    c.alu_src_a = 2'd1; c.alu_src_b = 2'd2;
    c.imm_src = (o == 2'b01) ? 2'd1 : (o == 2'b10) ? 2'd2 : 2'd0;
    push({nm, "/decode"}, c);
    if (o == 2'b01) begin
      c = base();
      c.alu_src_b = 2'd1; c.imm_src = 2'd1;
      push({nm, "/memadr"}, c);
      if (f[0]) begin
        c = base(); c.adr_src = 1'b1;
        push({nm, "/memread"}, c);
        c = base(); c.result_src = 2'd1;
        c.reg_write = ok && (r != 4'd15);
        c.pc_write = ok && (r == 4'd15);
        push({nm, "/memwb"}, c);
      end else begin
        c = base(); c.adr_src = 1'b1; c.mem_write = ok;
        push({nm, "/memwrite"}, c);
      end
    end else if (o == 2'b00) begin
      c = base();
      c.alu_src_b = f[5] ? 2'd1 : 2'd0;
      c.alu_ctl = f[4:1];
      push({nm, "/exec"}, c);
      c = base();
      if (f[4:3] != 2'b10) begin
        c.reg_write = ok && (r != 4'd15);
        c.pc_write = ok && (r == 4'd15);
      end
      push({nm, "/aluwb"}, c);
    end else if (o == 2'b10) begin
      c = base();
      c.alu_src_a = 2'd2; c.alu_src_b = 2'd1; c.imm_src = 2'd2;
      c.result_src = 2'd2; c.pc_write = ok;
      push({nm, "/branch"}, c);
    end
  endtask

  task automatic run_cycles(input int n);
    ctl_t  e;
    string t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk_ctl(t, observed(), e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ir(input logic [3:0] c, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] r,
                        input logic [3:0] fl);
    cond = c; op = o; funct = f; rd = r; alu_flags = fl;
  endtask

  task automatic instr(input string nm, input logic [3:0] c,
                       input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] r, input logic [3:0] fl,
                       input logic ok);
    set_ir(c, o, f, r, fl);
    push_instr(nm, o, f, r, ok);
    run_cycles(exp_q.size());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk4("rst_strobes", {pc_write, ir_write, reg_write, mem_write}, 4'b0000);
    chk4("rst_flags", flags_q, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;

    instr("add",  4'hE, 2'b00, 6'b001000, 4'd13, 4'b0000, 1'b1);
    instr("ldr",  4'hE, 2'b01, 6'b011001, 4'd14, 4'b0000, 1'b1);
    instr("str",  4'hE, 2'b01, 6'b011000, 4'd14, 4'b0000, 1'b1);
    instr("cmp",  4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, 1'b1);
    chk4("cmp_flags", flags_q, 4'b0100);
    instr("beq",  4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 1'b1);
    instr("bne",  4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 1'b0);
    instr("addne", 4'h1, 2'b00, 6'b001000, 4'd3, 4'b0000, 1'b0);
    instr("addpc", 4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, 1'b1);
    instr("ldrpc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 1'b1);
    instr("addsne", 4'h1, 2'b00, 6'b001001, 4'd2, 4'b1111, 1'b0);
    chk4("nohold_flags", flags_q, 4'b0100);
    instr("adds", 4'hE, 2'b00, 6'b001001, 4'd2, 4'b0010, 1'b1);
    chk4("adds_flags", flags_q, 4'b0010);
    instr("bcs", 4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b1);
    instr("bhi", 4'h8, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b1);
    instr("blt", 4'hB, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);
    instr("bnv", 4'hF, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b0);
    instr("op11", 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 1'b1);
    instr("orri", 4'hE, 2'b00, 6'b111000, 4'd1, 4'b0000, 1'b1);

    // Reset lands on the MEMWRITE cycle of a store.
    set_ir(4'hE, 2'b01, 6'b011000, 4'd1, 4'b0000);
    push_instr("strx", 2'b01, 6'b011000, 4'd1, 1'b1);
    run_cycles(3);
    exp_q.delete();
    tag_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk4("rst_mw_strobes", {pc_write, ir_write, reg_write, mem_write}, 4'b0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    instr("str2", 4'hE, 2'b01, 6'b011000, 4'd1, 4'b0000, 1'b1);

    // Reset lands on the EXECI cycle of a flag-setting op.
    set_ir(4'hE, 2'b00, 6'b101001, 4'd4, 4'b1001);
    push_instr("addsi", 2'b00, 6'b101001, 4'd4, 1'b1);
    run_cycles(2);
    exp_q.delete();
    tag_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk4("rst_ex_strobes", {pc_write, ir_write, reg_write, mem_write}, 4'b0000);
    @(posedge clk);
    #1;
    chk4("rst_ex_flags", flags_q, 4'b0000);
    reset = 1'b0;
    instr("add2", 4'hE, 2'b00, 6'b001000, 4'd5, 4'b0000, 1'b1);

`ifdef MEM_WAIT_EN
    begin
      ctl_t c;
      c = base();
      c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.result_src = 2'd2;
      set_ir(4'hE, 2'b00, 6'b001000, 4'd6, 4'b0000);
      mem_ready = 1'b0;
      push("wait0", c);
      push("wait1", c);
      run_cycles(2);
      mem_ready = 1'b1;
      instr("addw", 4'hE, 2'b00, 6'b001000, 4'd6, 4'b0000, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
